// File: rtl/conv_seq_engine_pkg.sv
// Shared types and helpers for the sequential convolution engine.
//   state_t  : engine FSM states (IDLE, MAC, WRITE, DONE)
//   cnt_w()  : width of a counter that spans 0..n-1 (never less than 1 bit)
//   sat_acc(): clamps a sign-extended accumulator into a signed out_w range,
//              optionally forcing negative values to zero (ReLU)
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Wide working width for saturation so any ACC_W up to 64 fits.
  localparam int SAT_W = 64;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic signed [SAT_W-1:0] sat_acc(
    input logic signed [SAT_W-1:0] acc,
    input int                      out_w,
    input logic                    relu
  );
    logic signed [SAT_W-1:0] one;
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    one   = 64'sd1;
    max_v = (one <<< (out_w - 1)) - one;
    min_v = -(one <<< (out_w - 1));
    if (relu && (acc < 0)) return '0;
    if (acc > max_v)       return max_v;
    if (acc < min_v)       return min_v;
    return acc;
  endfunction

endpackage

// File: rtl/conv_seq_engine_if.sv
// Bus between a convolution requester and conv_seq_engine.
//   start  : master -> slave, one-cycle request, only looked at while the engine is idle
//   a_flat : master -> slave, IN_DIM x IN_DIM tile, row-major, element 0 in LSBs
//   b_flat : master -> slave, K_DIM x K_DIM kernel, row-major, element 0 in LSBs
//   busy   : slave -> master, high from the cycle after an accepted start through done
//   done   : slave -> master, one-cycle pulse when every c_flat slot is valid
//   c_flat : slave -> master, OUT_DIM x OUT_DIM results, row-major, element 0 in LSBs
// Handshake: start is accepted on a rising edge only when busy is low; a_flat and
// b_flat must stay stable until done has been seen. There is no back-pressure on done.
interface conv_seq_engine_if #(
  parameter int IN_DIM = 4,
  parameter int K_DIM  = 3,
  parameter int DATA_W = 8,
  parameter int OUT_W  = 8
);
  localparam int OUT_DIM = IN_DIM - K_DIM + 1;

  logic                               start;
  logic [IN_DIM*IN_DIM*DATA_W-1:0]    a_flat;
  logic [K_DIM*K_DIM*DATA_W-1:0]      b_flat;
  logic                               busy;
  logic                               done;
  logic [OUT_DIM*OUT_DIM*OUT_W-1:0]   c_flat;

  modport master (output start, a_flat, b_flat, input busy, done, c_flat);
  modport slave  (input start, a_flat, b_flat, output busy, done, c_flat);
endinterface

// File: rtl/conv_seq_engine_mac_pe.sv
// conv_mac_pe: single multiply-accumulate processing element.
//   clk, rst_n    : clock, asynchronous active-low reset (accumulator -> 0)
//   i_en          : accumulate this cycle
//   i_clear_first : first tap of a pixel; accumulator is loaded with the product
//   i_a, i_b      : signed DATA_W operands
//   o_acc         : registered signed ACC_W accumulator
module conv_mac_pe #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_en,
  input  logic                     i_clear_first,
  input  logic signed [DATA_W-1:0] i_a,
  input  logic signed [DATA_W-1:0] i_b,
  output logic signed [ACC_W-1:0]  o_acc
);

  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_prod_ext;
  logic signed [ACC_W-1:0]    r_acc;

  assign w_prod     = i_a * i_b;
  assign w_prod_ext = ACC_W'(w_prod);  // signed source, so this sign-extends

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= i_clear_first ? w_prod_ext : (r_acc + w_prod_ext);
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/conv_seq_engine.sv
// conv_seq_engine: time-multiplexed valid-mode 2-D convolution (stride 1, flipped
// kernel) using one MAC PE: c[r][c] = sum a[r+i][c+j] * b[K-1-i][K-1-j].
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : conv_seq_engine_if slave (start, a_flat, b_flat, busy, done, c_flat)
//   o_dbg_state : current FSM state for observation
// Each output pixel takes K_DIM^2 MAC cycles plus one WRITE cycle; a run ends with
// one DONE cycle. c_flat keeps its contents between runs and is only zeroed by reset.
// Build option: define CONV_SEQ_RELU_EN to store 0 for negative pixels.
module conv_seq_engine
  import conv_pkg::*;
#(
  parameter int IN_DIM = 4,
  parameter int K_DIM  = 3,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20,
  parameter int OUT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  conv_seq_engine_if.slave  bus,
  output state_t            o_dbg_state
);

  localparam int OUT_DIM = IN_DIM - K_DIM + 1;
  localparam int KW      = cnt_w(K_DIM);
  localparam int OW      = cnt_w(OUT_DIM);

`ifdef CONV_SEQ_RELU_EN
  localparam logic RELU_EN = 1'b1;
`else
  localparam logic RELU_EN = 1'b0;
`endif

  state_t                            r_state;
  state_t                            w_next;
  logic [KW-1:0]                     r_kc;
  logic [KW-1:0]                     r_kr;
  logic [OW-1:0]                     r_oc;
  logic [OW-1:0]                     r_orow;
  logic [OUT_DIM*OUT_DIM*OUT_W-1:0]  r_c_flat;

  logic                              w_last_tap;
  logic                              w_last_pix;
  logic                              w_first_tap;
  logic                              w_mac_en;
  int                                w_a_idx;
  int                                w_b_idx;
  int                                w_pix;
  logic signed [DATA_W-1:0]          w_a_op;
  logic signed [DATA_W-1:0]          w_b_op;
  logic signed [ACC_W-1:0]           w_acc;
  logic [OUT_W-1:0]                  w_sat;

  assign w_first_tap = (r_kc == '0) && (r_kr == '0);
  assign w_last_tap  = (r_kc == KW'(K_DIM - 1)) && (r_kr == KW'(K_DIM - 1));
  assign w_last_pix  = (r_oc == OW'(OUT_DIM - 1)) && (r_orow == OW'(OUT_DIM - 1));
  assign w_mac_en    = (r_state == ST_MAC);

  // Operand selection: tile walks forward, kernel walks backward (the flip).
  always_comb begin
    w_a_idx = (int'(r_orow) + int'(r_kr)) * IN_DIM + int'(r_oc) + int'(r_kc);
    w_b_idx = (K_DIM - 1 - int'(r_kr)) * K_DIM + (K_DIM - 1 - int'(r_kc));
    w_pix   = int'(r_orow) * OUT_DIM + int'(r_oc);
    w_a_op  = bus.a_flat[w_a_idx*DATA_W +: DATA_W];
    w_b_op  = bus.b_flat[w_b_idx*DATA_W +: DATA_W];
  end

  conv_mac_pe #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_pe (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_en          (w_mac_en),
    .i_clear_first (w_first_tap),
    .i_a           (w_a_op),
    .i_b           (w_b_op),
    .o_acc         (w_acc)
  );

  assign w_sat = OUT_W'(sat_acc(SAT_W'(w_acc), OUT_W, RELU_EN));

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // FSM next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (bus.start) w_next = ST_MAC;
      ST_MAC:   if (w_last_tap) w_next = ST_WRITE;
      ST_WRITE: w_next = w_last_pix ? ST_DONE : ST_MAC;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Counters (kc innermost, carrying into kr; oc carrying into orow) and result store
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_kc     <= '0;
      r_kr     <= '0;
      r_oc     <= '0;
      r_orow   <= '0;
      r_c_flat <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_kc   <= '0;
            r_kr   <= '0;
            r_oc   <= '0;
            r_orow <= '0;
          end
        end
        ST_MAC: begin
          if (r_kc == KW'(K_DIM - 1)) begin
            r_kc <= '0;
            r_kr <= (r_kr == KW'(K_DIM - 1)) ? '0 : r_kr + KW'(1);
          end else begin
            r_kc <= r_kc + KW'(1);
          end
        end
        ST_WRITE: begin
          r_c_flat[w_pix*OUT_W +: OUT_W] <= w_sat;
          if (r_oc == OW'(OUT_DIM - 1)) begin
            r_oc   <= '0;
            r_orow <= (r_orow == OW'(OUT_DIM - 1)) ? '0 : r_orow + OW'(1);
          end else begin
            r_oc <= r_oc + OW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (r_state != ST_IDLE);
  assign bus.done     = (r_state == ST_DONE);
  assign bus.c_flat   = r_c_flat;
  assign o_dbg_state  = r_state;

endmodule
